// File: rtl/axi4_burst_writer.sv
// AXI4 write master: one command (addr, len) plus a streamed beat interface becomes one INCR burst.
// Illegal commands (misaligned, too long, crossing 4 KB) complete with an error and no AXI traffic.
module axi4_burst_writer #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int MAX_LEN    = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    writer_start,
    output logic                    writer_ready,
    input  logic [ADDR_WIDTH-1:0]   writer_addr,
    input  logic [7:0]              writer_len,
    input  logic [DATA_WIDTH-1:0]   writer_data,
    input  logic                    writer_data_valid,
    output logic                    writer_data_ready,
    output logic                    writer_idle,
    output logic                    writer_done,
    output logic                    writer_error,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam logic [8:0] MAX_BEATS = 9'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, BURST, RESP, FIN} state_t;

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              cnt_q;
    logic                    aw_done_q, w_done_q, awvalid_q, error_q, ready_q, idle_q;

    logic        accept, illegal, misaligned, too_long, crosses;
    logic [16:0] span_end;
    logic        beats_left, aw_hs, w_hs, last_hs;

    // 17 bits hold 0xFFF plus 256 beats of 64 bytes without wrapping.
    always_comb begin
        span_end   = {5'b0, writer_addr[11:0]} + ((17'(writer_len) + 17'd1) << OFFS);
        misaligned = |writer_addr[OFFS-1:0];
        too_long   = (9'(writer_len) + 9'd1) > MAX_BEATS;
        crosses    = span_end > 17'd4096;
        illegal    = misaligned | too_long | crosses;
    end

    assign accept     = writer_start && ready_q;
    assign beats_left = (state == BURST) && !w_done_q;
    assign aw_hs      = awvalid_q && m_axi_awready;
    assign w_hs       = beats_left && writer_data_valid && m_axi_wready;
    assign last_hs    = w_hs && (cnt_q == 8'd0);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = illegal ? FIN : BURST;
            BURST:   if ((aw_done_q || aw_hs) && (w_done_q || last_hs)) next_state = RESP;
            RESP:    if (m_axi_bvalid) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        writer_ready      = ready_q;
        writer_idle       = idle_q;
        writer_done       = (state == FIN);
        writer_error      = (state == FIN) && error_q;
        writer_data_ready = beats_left && m_axi_wready;
        m_axi_awaddr      = addr_q;
        m_axi_awlen       = len_q;
        m_axi_awsize      = 3'(OFFS);
        m_axi_awburst     = 2'b01;
        m_axi_awvalid     = awvalid_q;
        m_axi_wdata       = writer_data;
        m_axi_wstrb       = '1;
        m_axi_wlast       = beats_left && (cnt_q == 8'd0);
        m_axi_wvalid      = beats_left && writer_data_valid;
        m_axi_bready      = (state == RESP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            error_q   <= 1'b0;
            ready_q   <= 1'b0;
            idle_q    <= 1'b0;
        end else begin
            ready_q <= (next_state == IDLE);
            idle_q  <= (next_state == IDLE);
            if (state == IDLE && accept) begin
                addr_q    <= writer_addr;
                len_q     <= writer_len;
                cnt_q     <= writer_len;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                error_q   <= illegal;
                awvalid_q <= !illegal;
            end else begin
                if (aw_hs) begin
                    awvalid_q <= 1'b0;
                    aw_done_q <= 1'b1;
                end
                if (w_hs) begin
                    if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
                    else               w_done_q <= 1'b1;
                end
                if (state == RESP && m_axi_bvalid) error_q <= (m_axi_bresp != 2'b00);
            end
        end
    end
endmodule

// File: tb/tb_axi4_burst_writer.sv
// Directed bench for axi4_burst_writer: a negedge monitor records AXI handshakes relative to
// the command-accept edge; scenario tasks drive stimulus and compare against hand-computed values.
module tb_axi4_burst_writer;
    localparam int DW = 256;
    localparam int AW = 64;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            writer_start = 1'b0;
    logic            writer_ready;
    logic [AW-1:0]   writer_addr = '0;
    logic [7:0]      writer_len = '0;
    logic [DW-1:0]   writer_data = '0;
    logic            writer_data_valid = 1'b0;
    logic            writer_data_ready;
    logic            writer_idle, writer_done, writer_error;
    logic [AW-1:0]   m_axi_awaddr;
    logic [7:0]      m_axi_awlen;
    logic [2:0]      m_axi_awsize;
    logic [1:0]      m_axi_awburst;
    logic            m_axi_awvalid;
    logic            m_axi_awready = 1'b0;
    logic [DW-1:0]   m_axi_wdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid;
    logic            m_axi_wready = 1'b1;
    logic [1:0]      m_axi_bresp = 2'b00;
    logic            m_axi_bvalid = 1'b1;
    logic            m_axi_bready;

    axi4_burst_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LEN(256)) dut (
        .clock(clock), .reset(reset),
        .writer_start(writer_start), .writer_ready(writer_ready),
        .writer_addr(writer_addr), .writer_len(writer_len),
        .writer_data(writer_data), .writer_data_valid(writer_data_valid),
        .writer_data_ready(writer_data_ready), .writer_idle(writer_idle),
        .writer_done(writer_done), .writer_error(writer_error),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // monitor state, written only by the monitor
    int          acc_cyc = 0;
    int          aw_cnt = 0, aw_cyc = -1, w_cnt = 0, wlast_cnt = 0, strb_bad = 0;
    int          done_cnt = 0, done_cyc = -1, bready_cyc = -1, rdy_cyc = -1, awv_seen = 0;
    logic        done_err = 1'b0;
    logic [63:0] aw_addr = '0;
    logic [7:0]  aw_len = '0;
    logic [2:0]  aw_size = '0;
    logic [1:0]  aw_burst = '0;
    logic [31:0] w_dat [0:15];
    logic        w_lst [0:15];

    always @(negedge clock) begin
        if (writer_start && writer_ready) begin
            acc_cyc = cyc; aw_cnt = 0; aw_cyc = -1; w_cnt = 0; wlast_cnt = 0; strb_bad = 0;
            done_cnt = 0; done_cyc = -1; bready_cyc = -1; rdy_cyc = -1; awv_seen = 0; done_err = 1'b0;
        end else begin
            if (m_axi_awvalid) awv_seen++;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_cnt++; aw_cyc = cyc - acc_cyc;
                aw_addr = m_axi_awaddr; aw_len = m_axi_awlen;
                aw_size = m_axi_awsize; aw_burst = m_axi_awburst;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (w_cnt < 16) begin
                    w_dat[w_cnt] = m_axi_wdata[31:0];
                    w_lst[w_cnt] = m_axi_wlast;
                end
                w_cnt++;
                if (m_axi_wlast) wlast_cnt++;
                if (m_axi_wstrb != {(DW/8){1'b1}}) strb_bad++;
            end
            if (m_axi_bready && bready_cyc < 0) bready_cyc = cyc - acc_cyc;
            if (writer_done) begin
                done_cnt++; done_cyc = cyc - acc_cyc; done_err = writer_error;
            end
            if (writer_ready && rdy_cyc < 0) rdy_cyc = cyc - acc_cyc;
        end
    end

    // stimulus state, written only by tasks
    logic [31:0] src [0:15];
    int          nbeats = 0, ptr = 0, aw_delay = 0;
    logic        wr_alt = 1'b0;

    task automatic step();
        logic hs;
        hs = writer_data_valid && writer_data_ready;
        @(posedge clock);
        #1;
        if (hs) ptr++;
        writer_data = '0;
        writer_data[31:0] = (ptr < 16) ? src[ptr] : 32'd0;
        writer_data_valid = (ptr < nbeats);
        m_axi_wready = wr_alt ? ((cyc % 2) == 1) : 1'b1;
        m_axi_awready = ((cyc - acc_cyc) > aw_delay);
        #1;
    endtask

    task automatic issue(input logic [63:0] a, input logic [7:0] l, input int n, input logic [31:0] base);
        int t;
        for (int i = 0; i < 16; i++) src[i] = base + 32'(i);
        nbeats = n;
        ptr = 0;
        writer_data = '0;
        writer_data[31:0] = src[0];
        writer_data_valid = (n > 0);
        t = 0;
        while (!writer_ready && t < 50) begin step(); t++; end
        checks++;
        if (!writer_ready) begin
            errors++; $display("FAIL issue_ready: ready=%0b required 1", writer_ready);
        end
        writer_addr = a; writer_len = l; writer_start = 1'b1;
        #1;
        step();
        writer_start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt == 0 && t < 200) begin step(); t++; end
        step(); step();
        checks++;
        if (done_cnt == 0) begin
            errors++; $display("FAIL done_timeout: done_cnt=%0d required >0", done_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step(); step();
        checks++;
        if ({writer_ready, writer_idle, writer_done, writer_error} !== 4'b0000) begin
            errors++; $display("FAIL reset_status: got %b required 0000",
                               {writer_ready, writer_idle, writer_done, writer_error});
        end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, writer_data_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_axi: got %b required 0000",
                               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, writer_data_ready});
        end
        reset = 1'b0;
        step();
        checks++;
        if ({writer_ready, writer_idle} !== 2'b11) begin
            errors++; $display("FAIL reset_release: ready/idle=%b required 11", {writer_ready, writer_idle});
        end
    endtask

    task automatic test_single_beat();
        wr_alt = 1'b0; aw_delay = 0; m_axi_bresp = 2'b00;
        issue(64'h40, 8'd0, 1, 32'd101);
        wait_done();
        checks++;
        if (aw_cnt !== 1 || aw_addr !== 64'h40 || aw_len !== 8'd0 || aw_cyc !== 1) begin
            errors++; $display("FAIL single_aw: cnt=%0d addr=%0h len=%0d cyc=%0d required 1/40/0/1",
                               aw_cnt, aw_addr, aw_len, aw_cyc);
        end
        checks++;
        if (aw_size !== 3'd5 || aw_burst !== 2'b01 || strb_bad !== 0) begin
            errors++; $display("FAIL single_fixed: size=%0d burst=%b strb_bad=%0d required 5/01/0",
                               aw_size, aw_burst, strb_bad);
        end
        checks++;
        if (w_cnt !== 1 || w_dat[0] !== 32'd101 || w_lst[0] !== 1'b1) begin
            errors++; $display("FAIL single_w: cnt=%0d data=%0d last=%b required 1/101/1",
                               w_cnt, w_dat[0], w_lst[0]);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 3 || done_err !== 1'b0) begin
            errors++; $display("FAIL single_done: cnt=%0d cyc=%0d err=%b required 1/3/0",
                               done_cnt, done_cyc, done_err);
        end
        checks++;
        if (bready_cyc !== 2 || rdy_cyc !== 4) begin
            errors++; $display("FAIL single_timing: bready_cyc=%0d ready_cyc=%0d required 2/4",
                               bready_cyc, rdy_cyc);
        end
    endtask

    task automatic test_wready_stall();
        wr_alt = 1'b1; aw_delay = 0; m_axi_bresp = 2'b00;
        issue(64'h1000, 8'd7, 8, 32'd101);
        wait_done();
        wr_alt = 1'b0;
        checks++;
        if (w_cnt !== 8 || wlast_cnt !== 1) begin
            errors++; $display("FAIL stall_beats: beats=%0d wlasts=%0d required 8/1", w_cnt, wlast_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (w_dat[i] !== 32'(101 + i) || w_lst[i] !== (i == 7)) begin
                errors++; $display("FAIL stall_beat%0d: data=%0d last=%b required %0d/%b",
                                   i, w_dat[i], w_lst[i], 101 + i, (i == 7));
            end
        end
        checks++;
        if (aw_cnt !== 1 || aw_addr !== 64'h1000 || aw_len !== 8'd7 || done_cnt !== 1 || done_err !== 1'b0) begin
            errors++; $display("FAIL stall_aw_done: aw=%0d addr=%0h len=%0d done=%0d err=%b required 1/1000/7/1/0",
                               aw_cnt, aw_addr, aw_len, done_cnt, done_err);
        end
    endtask

    task automatic test_aw_late();
        wr_alt = 1'b0; aw_delay = 5; m_axi_bresp = 2'b00;
        issue(64'h800, 8'd3, 4, 32'd301);
        wait_done();
        aw_delay = 0;
        checks++;
        if (w_cnt !== 4 || aw_cyc !== 6) begin
            errors++; $display("FAIL awlate_order: beats=%0d aw_cyc=%0d required 4/6", w_cnt, aw_cyc);
        end
        checks++;
        if (bready_cyc !== 7 || done_cyc !== 8 || done_cnt !== 1 || done_err !== 1'b0) begin
            errors++; $display("FAIL awlate_resp: bready_cyc=%0d done_cyc=%0d done=%0d err=%b required 7/8/1/0",
                               bready_cyc, done_cyc, done_cnt, done_err);
        end
    endtask

    task automatic test_illegal();
        // 0xFE0 + 2 * 32 bytes = 0x1020: crosses the 4 KB page
        issue(64'hFE0, 8'd1, 2, 32'd401);
        wait_done();
        checks++;
        if (awv_seen !== 0 || w_cnt !== 0 || done_cyc !== 1 || done_err !== 1'b1 || rdy_cyc !== 2) begin
            errors++; $display("FAIL cross4k: awv=%0d beats=%0d done_cyc=%0d err=%b rdy=%0d required 0/0/1/1/2",
                               awv_seen, w_cnt, done_cyc, done_err, rdy_cyc);
        end
        issue(64'h41, 8'd0, 1, 32'd411);
        wait_done();
        checks++;
        if (awv_seen !== 0 || w_cnt !== 0 || done_cyc !== 1 || done_err !== 1'b1) begin
            errors++; $display("FAIL misaligned: awv=%0d beats=%0d done_cyc=%0d err=%b required 0/0/1/1",
                               awv_seen, w_cnt, done_cyc, done_err);
        end
        // ends exactly on the 4 KB boundary: legal
        issue(64'hFE0, 8'd0, 1, 32'd421);
        wait_done();
        checks++;
        if (aw_cnt !== 1 || w_cnt !== 1 || w_dat[0] !== 32'd421 || done_err !== 1'b0) begin
            errors++; $display("FAIL edge4k: aw=%0d beats=%0d data=%0d err=%b required 1/1/421/0",
                               aw_cnt, w_cnt, w_dat[0], done_err);
        end
    endtask

    task automatic test_slverr();
        m_axi_bresp = 2'b10;
        issue(64'h200, 8'd3, 4, 32'd501);
        wait_done();
        checks++;
        if (w_cnt !== 4 || done_cnt !== 1 || done_err !== 1'b1) begin
            errors++; $display("FAIL slverr: beats=%0d done=%0d err=%b required 4/1/1", w_cnt, done_cnt, done_err);
        end
        m_axi_bresp = 2'b00;
        issue(64'h300, 8'd0, 1, 32'd601);
        wait_done();
        checks++;
        if (aw_cnt !== 1 || w_dat[0] !== 32'd601 || done_cnt !== 1 || done_err !== 1'b0) begin
            errors++; $display("FAIL after_slverr: aw=%0d data=%0d done=%0d err=%b required 1/601/1/0",
                               aw_cnt, w_dat[0], done_cnt, done_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        wr_alt = 1'b0; aw_delay = 0; m_axi_bresp = 2'b00;
        issue(64'h2000, 8'd7, 8, 32'd701);
        step(); step();
        reset = 1'b1;
        step();
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, writer_data_ready} !== 4'b0000) begin
            errors++; $display("FAIL midreset_axi: got %b required 0000",
                               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, writer_data_ready});
        end
        checks++;
        if ({writer_ready, writer_idle, writer_done} !== 3'b000) begin
            errors++; $display("FAIL midreset_status: got %b required 000",
                               {writer_ready, writer_idle, writer_done});
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({writer_ready, writer_idle} !== 2'b11 || done_cnt !== 0) begin
            errors++; $display("FAIL midreset_release: ready/idle=%b done=%0d required 11/0",
                               {writer_ready, writer_idle}, done_cnt);
        end
        nbeats = 0;
        issue(64'h3000, 8'd1, 2, 32'd801);
        wait_done();
        checks++;
        if (w_cnt !== 2 || w_dat[0] !== 32'd801 || w_dat[1] !== 32'd802 || done_err !== 1'b0) begin
            errors++; $display("FAIL post_reset_burst: beats=%0d d0=%0d d1=%0d err=%b required 2/801/802/0",
                               w_cnt, w_dat[0], w_dat[1], done_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) src[i] = 32'd0;
        test_reset();
        test_single_beat();
        test_wready_stall();
        test_aw_late();
        test_illegal();
        test_slverr();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
